bcd_cascade_counter: RTL and testbench
======================================

# bcd_cascade_counter

Parametrised multi-digit modulo-M up/down counter: successor of the single-digit decimal counter, generalised to DIGITS cascaded digits of arbitrary modulus. Adds count enable, synchronous parallel load, and a wrap/saturate mode. Used for display counters, timers and event tallies, with registered overflow/underflow flags for chaining into further logic.

## Interface
- DIGITS, 4: number of cascaded digits, 1..8.
- MODULUS, 10: per-digit modulus, 2..16; digit width DW = max(1, $clog2(MODULUS)).
- SATURATE, 0: 0 = wrap at extremes; 1 = hold at extremes.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- en  in  1  count enable.
- load  in  1  synchronous parallel load; priority over en.
- dir  in  1  0 = count up, 1 = count down.
- data  in  DIGITS*DW  load value; digit i at bits [i*DW +: DW], digit 0 least significant.
- count  out  DIGITS*DW  current value, same packing as data.
- sup  out  1  registered overflow flag (up past all-max).
- inf  out  1  registered underflow flag (down past all-zero).

## Operation
- Priority per edge: rst_n > load > en > hold.
- Reset (rst_n=1, async): count = 0, sup = 0, inf = 0, held while rst_n high.
- Load: each digit takes its data field. A field >= MODULUS is clamped to MODULUS-1. sup = inf = 0.
- Hold (en=0, load=0): count unchanged. sup = inf = 0.
- Count up (en=1, dir=0):
  - Digit 0 always steps.
  - Digit i steps iff digits 0..i-1 are all MODULUS-1.
  - A stepping digit at MODULUS-1 becomes 0; otherwise it increments.
- Count down (en=1, dir=1):
  - Digit i steps iff digits 0..i-1 are all 0.
  - A stepping digit at 0 becomes MODULUS-1; otherwise it decrements.
- Overflow, count all MODULUS-1 and counting up:
  - SATURATE=0: count becomes all 0, sup = 1.
  - SATURATE=1: count holds, sup = 1.
- Underflow, count all 0 and counting down:
  - SATURATE=0: count becomes all MODULUS-1, inf = 1.
  - SATURATE=1: count holds, inf = 1.
- Any other counting cycle: sup = inf = 0. sup and inf are never both 1.
- A digit holding an illegal value (>= MODULUS) is never produced by the block. This is guaranteed by the load clamp.
- dir may change every cycle; there is no hysteresis.

## Timing
- Latency 1: a value sampled at edge k appears on count after edge k.
- sup/inf are registered and asserted in the same cycle count shows the wrapped or held extreme value. Each is a 1-cycle pulse per overflow/underflow event.
- In SATURATE mode, sup/inf stay high on consecutive cycles while en=1 and the counter remains pinned at the extreme in the same direction.
- Carry chain is combinational across all digits within one cycle; no ripple latency.
- Reset mid-count: outputs go to 0 asynchronously. The first count step occurs on the first rising edge after rst_n falls.
- load and en together: load wins, no count step that cycle.

## Structure
- Shared package bcd_counter_pkg:
  - digit-width function clog2_min1;
  - direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- Sub-module bcd_digit, one instance per digit, generated DIGITS times. Each instance:
  - takes step, dir, load and load value;
  - outputs its digit, is_max and is_zero;
  - does its own clamp on load.
- Top level:
  - builds prefix-AND carry/borrow enables from is_max/is_zero;
  - detects all-max/all-zero;
  - applies SATURATE gating and drives the sup/inf registers.

## Test plan
- Reset and up-count (DIGITS=2, MODULUS=10, SATURATE=0): rst_n pulse, en=1, dir=0 for 100 cycles -> count 00,01,...,09,10,...,99, then 00 with sup=1 for that single cycle; inf stays 0.
- Down wrap: load 00, dir=1, en=1 -> next cycle count 99 with inf=1; the following cycle 98 with inf=0.
- Load clamp and priority: data=0xCF with load=1, en=1 -> count 99 (both digits clamped to 9), no step, sup=inf=0.
- Saturate (SATURATE=1): load 98, up for 4 cycles -> 99, 99, 99, 99, with sup = 0, 1, 1, 1. Then dir=1 -> 98, sup=0.
- Non-decimal modulus (MODULUS=16, DIGITS=2): load 0xFE, up 3 cycles -> 0xFF, 0x00 (sup=1), 0x01.
- Async reset mid-count: assert rst_n between edges while count=57 -> count=0 and flags 0 immediately without a clock edge; release -> 01 after the next edge with en=1, dir=0.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the cascaded modulo-M counter: digit-width helper
// and the encoding of the count direction.
package bcd_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One digit of the cascade: modulo-MODULUS up/down step with a parallel load
// that clamps out-of-range values to MODULUS-1.
module bcd_digit
  import bcd_counter_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int DW      = clog2_min1(MODULUS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_i,
  input  logic          dir_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  output logic [DW-1:0] digit_o,
  output logic          is_max_o,
  output logic          is_zero_o
);

  localparam logic [DW-1:0] MAX_VAL = DW'(MODULUS - 1);
  localparam logic [DW:0]   MOD_EXT = (DW + 1)'(MODULUS);

  logic [DW-1:0] digit_q, digit_d;

  // Load outranks stepping; the top only raises step_i when this digit must move.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = ({1'b0, load_val_i} >= MOD_EXT) ? MAX_VAL : load_val_i;
    end else if (step_i) begin
      if (dir_i == DIR_UP) digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + 1'b1;
      else                 digit_d = (digit_q == '0) ? MAX_VAL : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit_o   = digit_q;
  assign is_max_o  = (digit_q == MAX_VAL);
  assign is_zero_o = (digit_q == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo-M up/down counter with parallel load, wrap or saturate
// at the extremes, and registered overflow/underflow pulses.
module bcd_cascade_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0,
  localparam int DW      = clog2_min1(MODULUS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic                 dir,
  input  logic [DIGITS*DW-1:0] data,
  output logic [DIGITS*DW-1:0] count,
  output logic                 sup,
  output logic                 inf
);

  logic [DIGITS-1:0] isMax, isZero, stepEn;
  logic overflow, underflow, freeze;
  logic upRun, downRun;
  logic sup_q, sup_d, inf_q, inf_d;

  // Digit i steps when every lower digit sits at the turning value for the
  // current direction; saturate mode freezes the whole chain at an extreme.
  always_comb begin
    overflow  = en && !load && (dir == DIR_UP)   && (&isMax);
    underflow = en && !load && (dir == DIR_DOWN) && (&isZero);
    freeze    = (SATURATE != 0) && (overflow || underflow);
    sup_d     = overflow;
    inf_d     = underflow;
    upRun     = 1'b1;
    downRun   = 1'b1;
    stepEn    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      stepEn[i] = en && !freeze && ((dir == DIR_UP) ? upRun : downRun);
      upRun     = upRun && isMax[i];
      downRun   = downRun && isZero[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit #(
      .MODULUS(MODULUS),
      .DW     (DW)
    ) uDigit (
      .clk       (clk),
      .rst_n     (rst_n),
      .step_i    (stepEn[g]),
      .dir_i     (dir),
      .load_i    (load),
      .load_val_i(data[g*DW +: DW]),
      .digit_o   (count[g*DW +: DW]),
      .is_max_o  (isMax[g]),
      .is_zero_o (isZero[g])
    );
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sup_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      sup_q <= sup_d;
      inf_q <= inf_d;
    end
  end

  assign sup = sup_q;
  assign inf = inf_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for the cascaded counter: three two-digit instances (decimal wrap,
// decimal saturate, hex wrap) checked against an integer-valued model.
module tb_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, load, dir;
  logic [7:0] data;
  logic [7:0] cnt  [3];
  logic       supV [3];
  logic       infV [3];

  int vectors     = 0;
  int miscompares = 0;

  int modOf [3] = '{10, 10, 16};
  bit satOf [3] = '{1'b0, 1'b1, 1'b0};
  int expVal[3];
  bit expSup[3];
  bit expInf[3];

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .dir(dir), .data(data),
    .count(cnt[0]), .sup(supV[0]), .inf(infV[0]));

  bcd_cascade_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(1)) dutSat (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .dir(dir), .data(data),
    .count(cnt[1]), .sup(supV[1]), .inf(infV[1]));

  bcd_cascade_counter #(.DIGITS(2), .MODULUS(16), .SATURATE(0)) dutHex (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .dir(dir), .data(data),
    .count(cnt[2]), .sup(supV[2]), .inf(infV[2]));

  function automatic int clampNib(input int nib, input int m);
    return (nib >= m) ? m - 1 : nib;
  endfunction

  function automatic logic [7:0] toDigits(input int v, input int m);
    logic [7:0] r;
    r[3:0] = 4'(v % m);
    r[7:4] = 4'(v / m);
    return r;
  endfunction

  // The model treats each counter as a plain integer in 0..M*M-1.
  task automatic modelEdge();
    int m, top;
    for (int i = 0; i < 3; i++) begin
      m = modOf[i];
      top = m * m - 1;
      expSup[i] = 1'b0;
      expInf[i] = 1'b0;
      if (rst_n) begin
        expVal[i] = 0;
      end else if (load) begin
        expVal[i] = clampNib(int'(data[3:0]), m) + m * clampNib(int'(data[7:4]), m);
      end else if (en && !dir) begin
        if (expVal[i] == top) begin
          expSup[i] = 1'b1;
          if (!satOf[i]) expVal[i] = 0;
        end else expVal[i] = expVal[i] + 1;
      end else if (en && dir) begin
        if (expVal[i] == 0) begin
          expInf[i] = 1'b1;
          if (!satOf[i]) expVal[i] = top;
        end else expVal[i] = expVal[i] - 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyInputs(input logic l, input logic e, input logic d, input logic [7:0] dat);
    load = l;
    en   = e;
    dir  = d;
    data = dat;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    applyInputs(1'b0, 1'b1, 1'b0, 8'h00);
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cnt[i] !== 8'h00 || supV[i] !== 1'b0 || infV[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset inst%0d: got count=%h sup=%b inf=%b, expected count=00 sup=0 inf=0",
                 i, cnt[i], supV[i], infV[i]);
      end
    end
  endtask

  task automatic test_up_count();
    rst_n = 1'b0;
    applyInputs(1'b0, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 100; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cnt[i] !== toDigits(expVal[i], modOf[i]) || supV[i] !== expSup[i] || infV[i] !== expInf[i]) begin
          miscompares++;
          $display("[TB] FAIL up_count c%0d inst%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                   c, i, cnt[i], supV[i], infV[i], toDigits(expVal[i], modOf[i]), expSup[i], expInf[i]);
        end
      end
    end
    vectors++;
    if (cnt[0] !== 8'h00 || supV[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL up_wrap_decimal: got count=%h sup=%b, expected count=00 sup=1", cnt[0], supV[0]);
    end
  endtask

  task automatic test_down_wrap();
    applyInputs(1'b1, 1'b0, 1'b0, 8'h00);
    cycle();
    applyInputs(1'b0, 1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cnt[i] !== toDigits(expVal[i], modOf[i]) || supV[i] !== expSup[i] || infV[i] !== expInf[i]) begin
          miscompares++;
          $display("[TB] FAIL down_wrap c%0d inst%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                   c, i, cnt[i], supV[i], infV[i], toDigits(expVal[i], modOf[i]), expSup[i], expInf[i]);
        end
      end
    end
  endtask

  task automatic test_load_clamp();
    applyInputs(1'b1, 1'b1, 1'b0, 8'hCF);
    cycle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cnt[i] !== toDigits(expVal[i], modOf[i]) || supV[i] !== expSup[i] || infV[i] !== expInf[i]) begin
        miscompares++;
        $display("[TB] FAIL load_clamp inst%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                 i, cnt[i], supV[i], infV[i], toDigits(expVal[i], modOf[i]), expSup[i], expInf[i]);
      end
    end
    vectors++;
    if (cnt[0] !== 8'h99) begin
      miscompares++;
      $display("[TB] FAIL load_clamp_decimal: got count=%h, expected count=99", cnt[0]);
    end
  endtask

  task automatic test_saturate();
    applyInputs(1'b1, 1'b0, 1'b0, 8'h98);
    cycle();
    applyInputs(1'b0, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) dir = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cnt[i] !== toDigits(expVal[i], modOf[i]) || supV[i] !== expSup[i] || infV[i] !== expInf[i]) begin
          miscompares++;
          $display("[TB] FAIL saturate c%0d inst%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                   c, i, cnt[i], supV[i], infV[i], toDigits(expVal[i], modOf[i]), expSup[i], expInf[i]);
        end
      end
    end
  endtask

  task automatic test_hex_modulus();
    applyInputs(1'b1, 1'b0, 1'b0, 8'hFE);
    cycle();
    applyInputs(1'b0, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cnt[i] !== toDigits(expVal[i], modOf[i]) || supV[i] !== expSup[i] || infV[i] !== expInf[i]) begin
          miscompares++;
          $display("[TB] FAIL hex c%0d inst%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                   c, i, cnt[i], supV[i], infV[i], toDigits(expVal[i], modOf[i]), expSup[i], expInf[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    applyInputs(1'b1, 1'b0, 1'b0, 8'h57);
    cycle();
    applyInputs(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expVal[i] = 0;
      expSup[i] = 1'b0;
      expInf[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cnt[i] !== 8'h00 || supV[i] !== 1'b0 || infV[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL async_reset inst%0d: got count=%h sup=%b inf=%b, expected count=00 sup=0 inf=0",
                 i, cnt[i], supV[i], infV[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    applyInputs(1'b0, 1'b1, 1'b0, 8'h00);
    cycle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cnt[i] !== 8'h01 || supV[i] !== 1'b0 || infV[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_release inst%0d: got count=%h sup=%b inf=%b, expected count=01 sup=0 inf=0",
                 i, cnt[i], supV[i], infV[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] dat;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       dat = 8'h99;
        1:       dat = 8'h00;
        default: dat = 8'($urandom);
      endcase
      applyInputs(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), dat);
      cycle();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cnt[i] !== toDigits(expVal[i], modOf[i]) || supV[i] !== expSup[i] || infV[i] !== expInf[i]) begin
          miscompares++;
          $display("[TB] FAIL random c%0d inst%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                   c, i, cnt[i], supV[i], infV[i], toDigits(expVal[i], modOf[i]), expSup[i], expInf[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    applyInputs(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      expVal[i] = 0;
      expSup[i] = 1'b0;
      expInf[i] = 1'b0;
    end
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_clamp();
    test_saturate();
    test_hex_modulus();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
